// File: rtl/icache_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped, read-only instruction cache. It answers fetch requests from
// the fetch stage and refills missing lines from a backing memory port.
// A hit returns its word one cycle after the request. A miss raises ic_busy,
// fetches the whole line (word 0 first) and then returns the requested word.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   fetch_req         fetch request valid (ignored while ic_busy=1)
//   fetch_pc          fetch byte address, bits [1:0] ignored
//   flush             invalidate all lines / abort an outstanding miss
//   ic_valid          one-cycle pulse, ic_inst is valid
//   ic_inst           returned instruction (holds while ic_valid=0)
//   ic_busy           refill in progress, fetch must hold off
//   mem_req/mem_addr  line refill request, held until mem_ack
//   mem_ack           memory accepted mem_req
//   mem_rvalid/rdata  refill data beats
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int ADDR       = 32,
  parameter int INST       = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic            flush,
  output logic            ic_valid,
  output logic [INST-1:0] ic_inst,
  output logic            ic_busy,
  output logic            mem_req,
  output logic [ADDR-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [INST-1:0] mem_rdata
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = ADDR - IDX - OFF - 2;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_e;

  // Address split of the incoming fetch.
  logic [OFF-1:0]  req_off;
  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic            unused_pc_bits;

  assign req_off        = fetch_pc[OFF+1:2];
  assign req_idx        = fetch_pc[OFF+IDX+1:OFF+2];
  assign req_tag        = fetch_pc[ADDR-1:OFF+IDX+2];
  assign unused_pc_bits = ^fetch_pc[1:0];

  // Storage arrays.
  logic [INST-1:0] data_mem [SETS*LINE_WORDS];
  logic [TAGW-1:0] tag_mem  [SETS];

  // Control state.
  state_e          state_q,    state_d;
  logic [SETS-1:0] valid_q,    valid_d;
  logic [TAGW-1:0] miss_tag_q, miss_tag_d;
  logic [IDX-1:0]  miss_idx_q, miss_idx_d;
  logic [OFF-1:0]  miss_off_q, miss_off_d;
  logic [OFF-1:0]  beat_q,     beat_d;
  logic            abort_q,    abort_d;
  logic [INST-1:0] word_q,     word_d;
  logic            ic_valid_q, ic_valid_d;
  logic [INST-1:0] ic_inst_q,  ic_inst_d;

  logic data_we;
  logic tag_we;
  logic hit;
  logic req_beat;

  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  // The beat that carries the word the fetch asked for.
  assign req_beat = (beat_q == miss_off_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    valid_d    = valid_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    miss_off_d = miss_off_q;
    beat_d     = beat_q;
    abort_d    = abort_q;
    word_d     = word_q;
    ic_valid_d = 1'b0;
    ic_inst_d  = ic_inst_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    ic_busy    = 1'b0;
    mem_req    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        // RESP delivers its word through ic_valid_q and accepts a new fetch
        // exactly like IDLE does.
        state_d = IDLE;
        if (flush) begin
          valid_d = '0;
        end else if (fetch_req) begin
          if (hit) begin
            ic_valid_d = 1'b1;
            ic_inst_d  = data_mem[{req_idx, req_off}];
          end else begin
            miss_tag_d       = req_tag;
            miss_idx_d       = req_idx;
            miss_off_d       = req_off;
            beat_d           = '0;
            abort_d          = 1'b0;
            // The old line in this set is about to be overwritten.
            valid_d[req_idx] = 1'b0;
            state_d          = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        ic_busy = 1'b1;
        mem_req = 1'b1;
        if (flush) begin
          valid_d = '0;
          abort_d = 1'b1;
        end
        if (mem_ack) begin
          state_d = REFILL;
        end
      end

      REFILL: begin
        ic_busy = 1'b1;
        if (flush) begin
          valid_d = '0;
          abort_d = 1'b1;
        end
        if (mem_rvalid) begin
          data_we = 1'b1;
          beat_d  = beat_q + OFF'(1);
          if (req_beat) begin
            word_d = mem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            if (abort_q || flush) begin
              // Aborted refill: the line stays invalid and nothing is returned.
              abort_d = 1'b0;
              state_d = IDLE;
            end else begin
              tag_we              = 1'b1;
              valid_d[miss_idx_q] = 1'b1;
              ic_valid_d          = 1'b1;
              ic_inst_d           = req_beat ? mem_rdata : word_q;
              state_d             = RESP;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      miss_off_q <= '0;
      beat_q     <= '0;
      abort_q    <= 1'b0;
      word_q     <= '0;
      ic_valid_q <= 1'b0;
      ic_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      miss_off_q <= miss_off_d;
      beat_q     <= beat_d;
      abort_q    <= abort_d;
      word_q     <= word_d;
      ic_valid_q <= ic_valid_d;
      ic_inst_q  <= ic_inst_d;
    end
  end

  // NOTE: the data and tag arrays carry no reset; the valid bits alone decide
  // whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{miss_idx_q, beat_q}] <= mem_rdata;
    end
    if (tag_we) begin
      tag_mem[miss_idx_q] <= miss_tag_q;
    end
  end

  assign ic_valid = ic_valid_q;
  assign ic_inst  = ic_inst_q;
  assign mem_addr = mem_req ? {miss_tag_q, miss_idx_q, {(OFF+2){1'b0}}} : '0;

endmodule
